// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types.
// Latency: n/a (types only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// Read port: combinational 2**ADDR_WIDTH:1 mux over the storage array.
// Latency: zero cycles, output follows rd_addr within the same cycle.
// Backpressure: none, always ready.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
    output logic [DATA_WIDTH-1:0]                      rd_data
);

    always_comb begin
        rd_data = '0;
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/reg_file.sv
// 2R1W register file, entries cleared by async reset; entry 0 is ordinary storage.
// Latency: reads combinational, write visible from the rising edge onward (no bypass).
// Backpressure: none, one write accepted every cycle wr_en is high.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Reset holds the array at zero, so reads return 0 and writes are dropped while low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    reg_file_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port1 (
        .mem     (mem_q),
        .rd_addr (rd_addr1),
        .rd_data (rd_data1)
    );

    reg_file_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port2 (
        .mem     (mem_q),
        .rd_addr (rd_addr2),
        .rd_data (rd_data2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read data queued at drive time, compared on sample.
module tb_reg_file;
    import reg_file_pkg::*;

    logic     clk;
    logic     rst_n;
    rf_addr_t rd_addr1;
    rf_data_t rd_data1;
    rf_addr_t rd_addr2;
    rf_data_t rd_data2;
    rf_addr_t wr_addr;
    rf_data_t wr_data;
    logic     wr_en;

    typedef struct {
        string    tag;
        rf_data_t exp;
    } sb_t;

    sb_t      sb_q[$];
    rf_data_t model [32];
    int       n_chk  = 0;
    int       n_pass = 0;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input rf_data_t obs, input rf_data_t exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic drive_rd(input int a1, input int a2, input string tag);
        sb_t e;
        rd_addr1 = rf_addr_t'(a1);
        rd_addr2 = rf_addr_t'(a2);
        e.tag = $sformatf("%s_p1_a%0d", tag, a1);
        e.exp = model[a1];
        sb_q.push_back(e);
        e.tag = $sformatf("%s_p2_a%0d", tag, a2);
        e.exp = model[a2];
        sb_q.push_back(e);
    endtask

    task automatic sample_rd();
        sb_t e;
        #1;
        if (sb_q.size() < 2) begin
            chk("sb_underflow", rf_data_t'(sb_q.size()), 32'd2);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, rd_data1, e.exp);
            e = sb_q.pop_front();
            chk(e.tag, rd_data2, e.exp);
        end
    endtask

    task automatic read_chk(input int a1, input int a2, input string tag);
        drive_rd(a1, a2, tag);
        sample_rd();
    endtask

    // Called at a negedge; returns at the following negedge with wr_en low.
    task automatic do_write(input int a, input rf_data_t d);
        wr_addr = rf_addr_t'(a);
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        if (rst_n) model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_en    = 1'b0;
        model_clear();

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk(0, 1, "reset");

        @(negedge clk);
        do_write(0, 32'h1234_5678);
        read_chk(0, 1, "basic");

        do_write(1, 32'hAABB_CCDD);
        read_chk(1, 0, "second");

        wr_addr = 5'd2;
        wr_data = 32'hDEAD_BEEF;
        wr_en   = 1'b0;
        repeat (3) @(negedge clk);
        read_chk(2, 2, "wr_dis");

        // Read-during-write: old value before the edge, new value from the edge on.
        wr_addr = 5'd3;
        wr_data = 32'hCAFE_F00D;
        wr_en   = 1'b1;
        read_chk(3, 3, "rdw_pre");
        @(posedge clk);
        model[3] = 32'hCAFE_F00D;
        #1;
        drive_rd(3, 3, "rdw_post");
        sample_rd();
        @(negedge clk);
        wr_en = 1'b0;
        read_chk(3, 0, "rdw_hold");

        for (int i = 0; i < 32; i++) do_write(i, rf_data_t'(i + 1));
        for (int i = 0; i < 32; i++) begin
            read_chk(i, (i + 7) % 32, "fill");
            @(negedge clk);
        end

        // Async reset between edges with a concurrent write request.
        wr_addr = 5'd5;
        wr_data = 32'hFFFF_FFFF;
        wr_en   = 1'b1;
        #1;
        rst_n = 1'b0;
        model_clear();
        read_chk(5, 31, "arst_now");
        read_chk(0, 17, "arst_now");
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            read_chk(i, 31 - i, "arst_hold");
        end

        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_chk(i, (i + 1) % 32, "post_rst");
            @(negedge clk);
        end

        do_write(7, 32'h5A5A_5A5A);
        read_chk(7, 5, "post_rst_wr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
